ram_2p_port_arbiter: RTL

- Shares one port of the dual-port 32-bit-word RAM (1-cycle read latency, byte-enable writes) between NumReq requesters, e.g. core data, debug module and DMA.
- Uses round-robin arbitration and returns read data to the requester that issued the read.
- Optionally zero-fills the whole RAM after reset before accepting any request.
- Sits between the requesters and the RAM's a_* or b_* port group.

---
 rtl/ram_2p_port_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/ram_2p_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between NumReq requesters.
// Optionally zero-fills the RAM after reset before arbitration starts.
// Read data is routed back to the requester that issued the read.
module ram_2p_port_arbiter #(
    parameter int NumReq       = 3,
    parameter int Width        = 32,
    parameter int Depth        = 128,
    parameter int AddrOffset   = 2,
    parameter bit ClearOnReset = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [NumReq-1:0]        req_i,
    input  logic [NumReq-1:0]        we_i,
    input  logic [4*NumReq-1:0]      be_i,
    input  logic [32*NumReq-1:0]     addr_i,
    input  logic [Width*NumReq-1:0]  wdata_i,
    output logic [NumReq-1:0]        gnt_o,
    output logic [NumReq-1:0]        rvalid_o,
    output logic [Width-1:0]         rdata_o,
    output logic                     init_done_o,
    output logic                     ram_req_o,
    output logic                     ram_we_o,
    output logic [3:0]               ram_be_o,
    output logic [31:0]              ram_addr_o,
    output logic [Width-1:0]         ram_wdata_o,
    input  logic                     ram_rvalid_i,
    input  logic [Width-1:0]         ram_rdata_i
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = (Depth > 1) ? $clog2(Depth) : 1;

    typedef enum logic {CLEAR, ARB} state_e;

    state_e          state, state_nxt;
    logic [CntW-1:0] cnt;
    logic [IdxW-1:0] ptr;
    logic [IdxW-1:0] win;
    logic            win_vld;
    logic            grant;
    logic            rd_pend;
    logic [IdxW-1:0] rd_idx;

    // Round-robin search: first requester after the last winner, wrapping.
    always_comb begin
        win     = '0;
        win_vld = 1'b0;
        for (int k = 1; k <= NumReq; k++) begin
            if (!win_vld && req_i[(int'(ptr) + k) % NumReq]) begin
                win_vld = 1'b1;
                win     = IdxW'((int'(ptr) + k) % NumReq);
            end
        end
    end

    // Next-state and RAM port muxing; everything forced low while in reset.
    always_comb begin
        state_nxt   = state;
        gnt_o       = '0;
        init_done_o = 1'b0;
        ram_req_o   = 1'b0;
        ram_we_o    = 1'b0;
        ram_be_o    = 4'h0;
        ram_addr_o  = 32'h0;
        ram_wdata_o = '0;
        grant       = 1'b0;
        if (rst_ni) begin
            case (state)
                CLEAR: begin
                    ram_req_o  = 1'b1;
                    ram_we_o   = 1'b1;
                    ram_be_o   = 4'hF;
                    ram_addr_o = 32'(cnt) << AddrOffset;
                    if (cnt == CntW'(Depth - 1)) state_nxt = ARB;
                end
                default: begin
                    init_done_o = 1'b1;
                    if (win_vld) begin
                        grant       = 1'b1;
                        gnt_o[win]  = 1'b1;
                        ram_req_o   = 1'b1;
                        ram_we_o    = we_i[win];
                        ram_be_o    = be_i[4*win +: 4];
                        ram_addr_o  = addr_i[32*win +: 32];
                        ram_wdata_o = wdata_i[Width*win +: Width];
                    end
                end
            endcase
        end
    end

    // State, clear counter, priority pointer and outstanding-read tracker.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= ClearOnReset ? CLEAR : ARB;
            cnt     <= '0;
            ptr     <= IdxW'(NumReq - 1);
            rd_pend <= 1'b0;
            rd_idx  <= '0;
        end else begin
            state <= state_nxt;
            if (state == CLEAR) cnt <= cnt + 1'b1;
            if (grant) ptr <= win;
            rd_pend <= grant && !we_i[win];
            if (grant) rd_idx <= win;
        end
    end

    // Read return: only the requester with a read in flight sees rvalid.
    always_comb begin
        rvalid_o = '0;
        if (rst_ni && rd_pend && ram_rvalid_i) rvalid_o[rd_idx] = 1'b1;
        rdata_o = rst_ni ? ram_rdata_i : '0;
    end

endmodule
